// File: rtl/dmem_tap_pkg.sv
// dmem_tap_pkg: shared types and helpers for the data-memory write tap.
//   DMEM_TAP_SEQ_W  width of the sequence tag carried in every entry
//   DMEM_TAP_LO/HI  default capture window (inclusive byte addresses)
//   tap_entry_t     one captured store {addr, data, seq}
//   in_window()     unsigned inclusive window test
package dmem_tap_pkg;

    localparam int          DMEM_TAP_SEQ_W = 16;
    localparam logic [31:0] DMEM_TAP_LO    = 32'h0000_0000;
    localparam logic [31:0] DMEM_TAP_HI    = 32'h0000_00FF;

    typedef struct packed {
        logic [31:0]               addr;
        logic [31:0]               data;
        logic [DMEM_TAP_SEQ_W-1:0] seq;
    } tap_entry_t;

    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/tap_fifo.sv
// tap_fifo: synchronous first-word-fall-through FIFO of tap_entry_t.
//   clk, reset    clock, synchronous active-high reset
//   clear         synchronous flush; discards any push/pop in the same cycle
//   push          write request; accepted when not full, or when full and a
//                 pop happens in the same cycle
//   push_entry    entry written on an accepted push
//   pop_req       consumer ready; ignored while empty
//   out_valid     FIFO non-empty
//   out_entry     entry at the read pointer (all zeros while empty)
//   level         occupancy 0..DEPTH
//   full          level == DEPTH
module tap_fifo
    import dmem_tap_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  tap_entry_t               push_entry,
    input  logic                     pop_req,
    output logic                     out_valid,
    output tap_entry_t               out_entry,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tap_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    tap_entry_t       mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;
    logic             wr_en;

    always_comb begin
        do_pop   = pop_req && (level_q != '0);
        // Full FIFO still accepts when the head leaves in the same cycle.
        do_push  = push && ((level_q != LVL_W'(DEPTH)) || do_pop);
        wr_en    = do_push && !clear;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; empty-state outputs are masked below instead.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem_q[wr_ptr_q] <= push_entry;
    end

    assign out_valid = (level_q != '0);
    assign full      = (level_q == LVL_W'(DEPTH));
    assign level     = level_q;
    assign out_entry = out_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/dmem_write_tap.sv
// dmem_write_tap: passive observer of the core's data-memory write bus.
// Stores whose byte address falls in [ADDR_LO, ADDR_HI] are tagged with a
// running sequence number and queued; entries drain over valid/ready.
//   clk, reset              clock, synchronous active-high reset
//   MemWrite/DataAdr/
//   WriteData               core store bus (observed only, never stalled)
//   clear                   synchronous flush of queue and counters
//   out_valid/out_ready     drain handshake
//   out_addr/out_data/
//   out_seq                 head entry
//   level, full             occupancy
//   overflow_cnt            saturating count of dropped in-window stores
module dmem_write_tap
    import dmem_tap_pkg::*;
#(
    parameter int          DEPTH   = 8,
    parameter logic [31:0] ADDR_LO = DMEM_TAP_LO,
    parameter logic [31:0] ADDR_HI = DMEM_TAP_HI,
    parameter int          SEQ_W   = DMEM_TAP_SEQ_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemWrite,
    input  logic [31:0]            DataAdr,
    input  logic [31:0]            WriteData,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_addr,
    output logic [31:0]            out_data,
    output logic [SEQ_W-1:0]       out_seq,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic [SEQ_W-1:0]       overflow_cnt
);

    // The entry struct has a fixed tag width, so SEQ_W must match it.
    if (SEQ_W != DMEM_TAP_SEQ_W) begin : g_bad_seq_w
        $error("dmem_write_tap: SEQ_W must equal DMEM_TAP_SEQ_W");
    end

    logic             hit;
    logic             pop;
    logic             drop;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SEQ_W-1:0] ovf_q, ovf_d;
    tap_entry_t       push_entry;
    tap_entry_t       head;

    always_comb begin
        hit  = MemWrite && in_window(DataAdr, ADDR_LO, ADDR_HI);
        pop  = out_valid && out_ready;
        drop = hit && full && !pop;

        push_entry      = '0;
        push_entry.addr = DataAdr;
        push_entry.data = WriteData;
        push_entry.seq  = seq_q;

        seq_d = seq_q;
        ovf_d = ovf_q;
        if (clear) begin
            seq_d = '0;
            ovf_d = '0;
        end else begin
            // Tag advances on every hit, dropped or not, so gaps reveal drops.
            if (hit) seq_d = seq_q + 1'b1;
            if (drop && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q <= '0;
            ovf_q <= '0;
        end else begin
            seq_q <= seq_d;
            ovf_q <= ovf_d;
        end
    end

    tap_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .push       (hit),
        .push_entry (push_entry),
        .pop_req    (out_ready),
        .out_valid  (out_valid),
        .out_entry  (head),
        .level      (level),
        .full       (full)
    );

    assign out_addr     = head.addr;
    assign out_data     = head.data;
    assign out_seq      = head.seq;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_dmem_write_tap.sv
module tb_dmem_write_tap;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [15:0] out_seq;
    logic [3:0]  level;
    logic        full;
    logic [15:0] overflow_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_write_tap dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .DataAdr      (DataAdr),
        .WriteData    (WriteData),
        .clear        (clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_seq      (out_seq),
        .level        (level),
        .full         (full),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1; MemWrite = 1'b0; clear = 1'b0; out_ready = 1'b0;
        DataAdr = '0; WriteData = '0;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; DataAdr = a; WriteData = d;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0d want 0", out_valid); end
        n_chk++; if (level !== 4'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", level); end
        n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %0d want 0", full); end
        n_chk++; if (overflow_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_ovf got %0d want 0", overflow_cnt); end
        n_chk++; if ({out_addr, out_data, out_seq} !== 80'd0) begin n_fail++; $display("FAIL rst_head got %h/%h/%h want 0", out_addr, out_data, out_seq); end
    endtask

    task automatic test_single();
        do_reset(3);
        out_ready = 1'b1;
        store(32'd100, 32'd7);
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0d want 1", out_valid); end
        n_chk++; if (out_addr !== 32'd100) begin n_fail++; $display("FAIL single_addr got %0d want 100", out_addr); end
        n_chk++; if (out_data !== 32'd7) begin n_fail++; $display("FAIL single_data got %0d want 7", out_data); end
        n_chk++; if (out_seq !== 16'd0) begin n_fail++; $display("FAIL single_seq got %0d want 0", out_seq); end
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained_valid got %0d want 0", out_valid); end
        n_chk++; if (level !== 4'd0) begin n_fail++; $display("FAIL single_drained_level got %0d want 0", level); end
        out_ready = 1'b0;
    endtask

    task automatic test_window();
        do_reset(1);
        store(32'd96, 32'h11);
        store(32'd100, 32'h22);
        store(32'd256, 32'h33);
        store(32'd300, 32'h44);
        n_chk++; if (level !== 4'd2) begin n_fail++; $display("FAIL win_level got %0d want 2", level); end
        n_chk++; if (overflow_cnt !== 16'd0) begin n_fail++; $display("FAIL win_ovf got %0d want 0", overflow_cnt); end
        n_chk++; if (out_addr !== 32'd96 || out_seq !== 16'd0) begin n_fail++; $display("FAIL win_head0 got %0d/seq %0d want 96/seq 0", out_addr, out_seq); end
        out_ready = 1'b1; tick();
        n_chk++; if (out_addr !== 32'd100 || out_seq !== 16'd1) begin n_fail++; $display("FAIL win_head1 got %0d/seq %0d want 100/seq 1", out_addr, out_seq); end
        tick(); out_ready = 1'b0;
        n_chk++; if (level !== 4'd0) begin n_fail++; $display("FAIL win_empty got %0d want 0", level); end
    endtask

    task automatic test_window_edges();
        do_reset(1);
        store(32'h0000_00FF, 32'h1);
        store(32'h0000_0100, 32'h2);
        store(32'h0000_0000, 32'h3);
        store(32'hFFFF_FFFF, 32'h4);
        n_chk++; if (level !== 4'd2) begin n_fail++; $display("FAIL edge_level got %0d want 2", level); end
        n_chk++; if (out_addr !== 32'hFF || out_seq !== 16'd0) begin n_fail++; $display("FAIL edge_hi got %h/seq %0d want ff/seq 0", out_addr, out_seq); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_chk++; if (out_addr !== 32'h0 || out_data !== 32'h3 || out_seq !== 16'd1) begin n_fail++; $display("FAIL edge_lo got %h/%h/seq %0d want 0/3/seq 1", out_addr, out_data, out_seq); end
    endtask

    task automatic test_overflow();
        do_reset(1);
        for (int i = 1; i <= 10; i++) store(32'h10 + 4 * i, i);
        n_chk++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %0d want 1", full); end
        n_chk++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got %0d want 8", level); end
        n_chk++; if (overflow_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_cnt got %0d want 2", overflow_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== 32'(i + 1) || out_seq !== 16'(i)) begin
                n_fail++;
                $display("FAIL ovf_drain%0d got v%0d d%0d s%0d want v1 d%0d s%0d", i, out_valid, out_data, out_seq, i + 1, i);
            end
            tick();
        end
        out_ready = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %0d want 0", out_valid); end
        store(32'h40, 32'd11);
        n_chk++; if (out_seq !== 16'd10 || out_data !== 32'd11) begin n_fail++; $display("FAIL ovf_nextseq got s%0d d%0d want s10 d11", out_seq, out_data); end
    endtask

    task automatic test_full_with_pop();
        do_reset(1);
        for (int i = 1; i <= 8; i++) store(32'h20 + 4 * i, i);
        out_ready = 1'b1;
        store(32'h80, 32'hAA);
        out_ready = 1'b0;
        n_chk++; if (level !== 4'd8) begin n_fail++; $display("FAIL fwp_level got %0d want 8", level); end
        n_chk++; if (overflow_cnt !== 16'd0) begin n_fail++; $display("FAIL fwp_ovf got %0d want 0", overflow_cnt); end
        n_chk++; if (out_data !== 32'd2) begin n_fail++; $display("FAIL fwp_head got %0d want 2", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (out_data !== ((i == 7) ? 32'hAA : 32'(i + 2))) begin
                n_fail++;
                $display("FAIL fwp_drain%0d got %h want %h", i, out_data, (i == 7) ? 32'hAA : 32'(i + 2));
            end
            tick();
        end
        out_ready = 1'b0;
        n_chk++; if (level !== 4'd0) begin n_fail++; $display("FAIL fwp_empty got %0d want 0", level); end
    endtask

    task automatic test_clear();
        do_reset(1);
        for (int i = 1; i <= 9; i++) store(32'h30 + 4 * i, i);
        out_ready = 1'b1; repeat (4) tick();
        n_chk++; if (level !== 4'd4 || overflow_cnt !== 16'd1) begin n_fail++; $display("FAIL clr_pre got l%0d o%0d want l4 o1", level, overflow_cnt); end
        clear = 1'b1;
        store(32'd100, 32'h99);
        clear = 1'b0; out_ready = 1'b0;
        n_chk++; if (level !== 4'd0) begin n_fail++; $display("FAIL clr_level got %0d want 0", level); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got %0d want 0", out_valid); end
        n_chk++; if (overflow_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_ovf got %0d want 0", overflow_cnt); end
        n_chk++; if (out_addr !== 32'd0) begin n_fail++; $display("FAIL clr_addr got %0d want 0", out_addr); end
        store(32'd100, 32'h55);
        n_chk++; if (out_seq !== 16'd0 || out_data !== 32'h55) begin n_fail++; $display("FAIL clr_after got s%0d d%h want s0 d55", out_seq, out_data); end
    endtask

    task automatic test_reset_midstream();
        do_reset(1);
        for (int i = 1; i <= 11; i++) store(32'h40 + 4 * i, i);
        out_ready = 1'b1; repeat (3) tick(); out_ready = 1'b0;
        n_chk++; if (level !== 4'd5 || overflow_cnt !== 16'd3) begin n_fail++; $display("FAIL rmid_pre got l%0d o%0d want l5 o3", level, overflow_cnt); end
        reset = 1'b1; out_ready = 1'b1;
        store(32'd100, 32'h77);
        reset = 1'b0; out_ready = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || level !== 4'd0 || full !== 1'b0 || overflow_cnt !== 16'd0 ||
            out_addr !== 32'd0 || out_data !== 32'd0 || out_seq !== 16'd0) begin
            n_fail++;
            $display("FAIL rmid_zero got v%0d l%0d f%0d o%0d a%h d%h s%0d want all 0",
                     out_valid, level, full, overflow_cnt, out_addr, out_data, out_seq);
        end
        store(32'd100, 32'd7);
        n_chk++; if (out_addr !== 32'd100 || out_data !== 32'd7 || out_seq !== 16'd0) begin n_fail++; $display("FAIL rmid_after got a%0d d%0d s%0d want a100 d7 s0", out_addr, out_data, out_seq); end
    endtask

    initial begin
        reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        clear = 1'b0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_window();
        test_window_edges();
        test_overflow();
        test_full_with_pop();
        test_clear();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_write_tap.md
Name: dmem_write_tap

Overview:
- Passive observer on the processor's data-memory write bus (MemWrite, DataAdr, WriteData), instantiated beside `top` and consuming what the core produces.
- Captures every store that falls inside a programmable address window.
- Each capture is tagged with a sequence number and buffered in a small FIFO.
- Entries are drained over a valid/ready port so benches and a future debug UART can check stores without probing core internals.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two and at least 2; elaboration error otherwise.
- ADDR_LO, 32'h0000_0000, lowest captured byte address, inclusive.
- ADDR_HI, 32'h0000_00FF, highest captured byte address, inclusive.
- SEQ_W, 16, width of the sequence tag and of the overflow counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  core store strobe, one per store cycle.
- DataAdr  in  32  store byte address.
- WriteData  in  32  store data.
- clear  in  1  synchronous flush.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_addr  out  32  head entry address.
- out_data  out  32  head entry data.
- out_seq  out  SEQ_W  head entry sequence tag.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- overflow_cnt  out  SEQ_W  count of dropped in-window stores, saturating.

Behaviour:
- Reset (reset=1 at a rising edge):
  - Read pointer, write pointer and level go to 0; seq counter and overflow_cnt go to 0.
  - out_valid=0, full=0.
  - out_addr, out_data and out_seq read 0 while empty.
  - Reset overrides every other input in that cycle.
- hit = MemWrite && DataAdr >= ADDR_LO && DataAdr <= ADDR_HI, using unsigned 32-bit compares.
  - Out-of-window stores are ignored entirely: no push, no seq increment.
- push_req = hit; pop = out_valid && out_ready.
- Push accepted when level < DEPTH, or when level == DEPTH and pop is asserted in the same cycle.
- On accepted push: the entry {DataAdr, WriteData, seq} is written at the write pointer and the write pointer advances modulo DEPTH.
- seq increments by 1 modulo 2^SEQ_W on every hit, whether accepted or dropped, so gaps in out_seq expose drops.
- Drop: hit && level == DEPTH && !pop.
  - Entry discarded.
  - overflow_cnt += 1, saturating at all-ones.
  - FIFO contents unchanged.
- Pop: the read pointer advances modulo DEPTH. out_ready while empty has no effect.
- level update, same cycle:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither happens.
- Output is first-word-fall-through, taken from registered storage.
  - A store captured at edge N makes out_valid=1 after edge N and is visible in cycle N+1.
  - out_valid = (level != 0).
  - out_* always present the entry at the read pointer.
- Ordering: entries leave in capture order; no reordering, no merging of repeated addresses.
- clear=1 (and reset=0):
  - Pointers, level, seq and overflow_cnt go to 0.
  - Any push or pop in that cycle is discarded.
  - Takes effect at that rising edge.
- full and level are registered-state derived and valid in the cycle after the update.
- Stores of the core's sequence arrive at most one per cycle. No back-pressure to the core exists: the core is never stalled.

Decomposition:
- Package dmem_tap_pkg holds:
  - tap_entry_t, a packed struct {addr[31:0], data[31:0], seq[SEQ_W-1:0]}.
  - The default window constants DMEM_TAP_LO and DMEM_TAP_HI.
  - A function in_window(addr, lo, hi).
- One sub-module, tap_fifo:
  - Generic synchronous FFWT FIFO of tap_entry_t with DEPTH entries.
  - push/pop/clear, level and full.
  - Accept-on-full-with-pop rule.
- dmem_write_tap keeps the window decode, seq counter and overflow counter.

Test Plan:
1. Reset held 3 cycles, then MemWrite=1, DataAdr=100, WriteData=7 for one cycle, out_ready=1 → next cycle out_valid=1, out_addr=100, out_data=7, out_seq=0; one cycle later out_valid=0, level=0.
2. Stores to addresses 96, 100, 256 and 300 with default window, out_ready=0 → level=2; entries (96,seq 0) and (100,seq 1); overflow_cnt=0.
3. Ten in-window stores with data 1..10, out_ready=0 → full=1, level=8, overflow_cnt=2; drain order is data 1..8 with seq 0..7; next store gets seq 10.
4. FIFO full, then a store with data 0xAA arrives while out_ready=1 → no drop; level stays 8; overflow_cnt unchanged; 0xAA is the last entry drained.
5. Four entries queued; assert clear for one cycle while a store and a pop occur → level=0, out_valid=0, overflow_cnt=0; the following store has out_seq=0.
6. Five entries queued plus overflow_cnt=3; reset asserted mid-stream for one cycle → all outputs 0 the next cycle; subsequent capture of (100,7) appears with out_seq=0.
